// File: rtl/rx_fifo_sched.sv
// rtl/rx_fifo_sched.sv - burst scheduler sharing one output port between the video and aux FIFOs
// Optional macro SCHED_STAT_EN adds saturating transfer and stall counters.
module rx_fifo_sched #(
   parameter int VID_BURST = 16,
   parameter int AUX_BURST = 32
) (
   input  logic        clk125,
   input  logic        sys_rst_n,
   input  logic        sched_en,
   input  logic        vid_empty,
   input  logic [28:0] vid_dout,
   output logic        vid_rd_en,
   input  logic        aux_empty,
   input  logic [23:0] aux_dout,
   output logic        aux_rd_en,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_sel,
   output logic [28:0] out_data,
   output logic [1:0]  grant
`ifdef SCHED_STAT_EN
   ,
   output logic [15:0] stat_vid_words,
   output logic [15:0] stat_aux_words,
   output logic [15:0] stat_stall
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      VID  = 2'b01,
      AUX  = 2'b10
   } state_t;

   localparam logic [7:0] VID_MAX = 8'(VID_BURST);
   localparam logic [7:0] AUX_MAX = 8'(AUX_BURST);

   state_t      state_q;
   logic [7:0]  cnt_q;
   logic [7:0]  cnt_d;
   logic        last_aux_q;
   logic        out_valid_q;
   logic        out_sel_q;
   logic [28:0] out_data_q;
   logic        slot_free;
   logic        vid_pop;
   logic        aux_pop;

   always_comb begin
      slot_free = !out_valid_q || out_ready;
      vid_pop   = (state_q == VID) && !vid_empty && slot_free && sched_en;
      aux_pop   = (state_q == AUX) && !aux_empty && slot_free && sched_en;
      cnt_d     = cnt_q + 8'd1;
   end

   always_ff @(posedge clk125 or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= 8'd0;
         last_aux_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_sel_q   <= 1'b0;
         out_data_q  <= 29'd0;
      end else begin
         // The output register loads on the pop edge, so a word is visible one clock after its pop.
         if (vid_pop) begin
            out_data_q  <= vid_dout;
            out_sel_q   <= 1'b0;
            out_valid_q <= 1'b1;
         end else if (aux_pop) begin
            out_data_q  <= {5'b0, aux_dout};
            out_sel_q   <= 1'b1;
            out_valid_q <= 1'b1;
         end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               cnt_q <= 8'd0;
               if (sched_en) begin
                  if (!aux_empty && (!last_aux_q || vid_empty)) state_q <= AUX;
                  else if (!vid_empty)                          state_q <= VID;
               end
            end
            VID: begin
               if (!sched_en || vid_empty || (vid_pop && cnt_d == VID_MAX)) begin
                  state_q    <= IDLE;
                  cnt_q      <= 8'd0;
                  last_aux_q <= 1'b0;
               end else if (vid_pop) begin
                  cnt_q <= cnt_d;
               end
            end
            AUX: begin
               // Leaving an aux grant hands the next decision to pending video.
               if (!sched_en || aux_empty || (aux_pop && cnt_d == AUX_MAX)) begin
                  state_q    <= IDLE;
                  cnt_q      <= 8'd0;
                  last_aux_q <= 1'b1;
               end else if (aux_pop) begin
                  cnt_q <= cnt_d;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= 8'd0;
            end
         endcase
      end
   end

   assign vid_rd_en = vid_pop;
   assign aux_rd_en = aux_pop;
   assign out_valid = out_valid_q;
   assign out_sel   = out_sel_q;
   assign out_data  = out_data_q;
   assign grant     = state_q;

`ifdef SCHED_STAT_EN
   logic [15:0] stat_vid_q;
   logic [15:0] stat_aux_q;
   logic [15:0] stat_stall_q;

   always_ff @(posedge clk125 or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         stat_vid_q   <= 16'd0;
         stat_aux_q   <= 16'd0;
         stat_stall_q <= 16'd0;
      end else begin
         if (out_valid_q && out_ready && !out_sel_q && stat_vid_q != 16'hFFFF)
            stat_vid_q <= stat_vid_q + 16'd1;
         if (out_valid_q && out_ready && out_sel_q && stat_aux_q != 16'hFFFF)
            stat_aux_q <= stat_aux_q + 16'd1;
         if (out_valid_q && !out_ready && stat_stall_q != 16'hFFFF)
            stat_stall_q <= stat_stall_q + 16'd1;
      end
   end

   assign stat_vid_words = stat_vid_q;
   assign stat_aux_words = stat_aux_q;
   assign stat_stall     = stat_stall_q;
`endif

endmodule

// File: tb/tb_rx_fifo_sched.sv
// tb/tb_rx_fifo_sched.sv - self-checking bench for rx_fifo_sched with FIFO models and a grant-sequence model
module tb_rx_fifo_sched;

   localparam int VID_B = 16;
   localparam int AUX_B = 32;

   logic        clk125;
   logic        sys_rst_n;
   logic        sched_en;
   logic        vid_empty;
   logic [28:0] vid_dout;
   logic        vid_rd_en;
   logic        aux_empty;
   logic [23:0] aux_dout;
   logic        aux_rd_en;
   logic        out_valid;
   logic        out_ready;
   logic        out_sel;
   logic [28:0] out_data;
   logic [1:0]  grant;
`ifdef SCHED_STAT_EN
   logic [15:0] stat_vid_words;
   logic [15:0] stat_aux_words;
   logic [15:0] stat_stall;
`endif

   rx_fifo_sched #(.VID_BURST(VID_B), .AUX_BURST(AUX_B)) dut (
      .clk125(clk125), .sys_rst_n(sys_rst_n), .sched_en(sched_en),
      .vid_empty(vid_empty), .vid_dout(vid_dout), .vid_rd_en(vid_rd_en),
      .aux_empty(aux_empty), .aux_dout(aux_dout), .aux_rd_en(aux_rd_en),
      .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel),
      .out_data(out_data), .grant(grant)
`ifdef SCHED_STAT_EN
      , .stat_vid_words(stat_vid_words), .stat_aux_words(stat_aux_words), .stat_stall(stat_stall)
`endif
   );

   initial clk125 = 1'b0;
   always #4 clk125 = ~clk125;

   int          checks = 0;
   int          failures = 0;
   int          vid_pops = 0;
   int          aux_pops = 0;
   logic [28:0] vid_q[$];
   logic [23:0] aux_q[$];
   logic [29:0] exp_q[$];
   byte         trace[$];
   byte         exp_tr[$];
   bit          pop_v = 0, pop_a = 0, pend = 0, prev_stall = 0, prev_en_low = 0, fair_on = 0;
   logic [29:0] pend_word, held;
   int          aux_run = 0, vid_run = 0;

   task automatic refresh();
      vid_empty = (vid_q.size() == 0);
      vid_dout  = vid_empty ? 29'd0 : vid_q[0];
      aux_empty = (aux_q.size() == 0);
      aux_dout  = aux_empty ? 24'd0 : aux_q[0];
   endtask

   task automatic load(input int nv, input int na);
      logic [31:0] r;
      for (int i = 0; i < nv; i++) begin r = $urandom(); vid_q.push_back(r[28:0]); end
      for (int i = 0; i < na; i++) begin r = $urandom(); aux_q.push_back(r[23:0]); end
      refresh();
   endtask

   // Expected per-cycle trace with out_ready=1: '-' idle, 'V'/'A' pop, 'v'/'a' granted but empty.
   task automatic build_model(input int nv_in, input int na_in, input bit last_in, input int len);
      int nv, na, b, c, n;
      bit last, src;
      nv = nv_in; na = na_in; last = last_in;
      exp_tr.delete();
      while (exp_tr.size() < len) begin
         exp_tr.push_back("-");
         if (na > 0 && (!last || nv == 0)) src = 1'b1;
         else if (nv > 0)                  src = 1'b0;
         else continue;
         b = src ? AUX_B : VID_B;
         c = src ? na : nv;
         n = (c < b) ? c : b;
         for (int i = 0; i < n; i++) exp_tr.push_back(src ? "A" : "V");
         if (n < b) exp_tr.push_back(src ? "a" : "v");
         if (src) na -= n; else nv -= n;
         last = src;
      end
   endtask

   task automatic compare_trace(input string name, input int len);
      int bad;
      byte got;
      bad = -1;
      for (int i = 0; i < len; i++)
         if (bad < 0 && (i >= trace.size() || trace[i] !== exp_tr[i])) bad = i;
      checks++;
      if (bad >= 0) begin
         failures++;
         got = (bad < trace.size()) ? trace[bad] : "?";
         $display("FAIL %s: trace differs at cycle %0d, got %c want %c", name, bad, got, exp_tr[bad]);
      end
   endtask

   always @(negedge clk125) begin
      byte c;
      if (!sys_rst_n) begin
         pend = 0; prev_stall = 0; prev_en_low = 0; aux_run = 0; vid_run = 0;
      end else begin
         checks++;
         if (vid_rd_en && aux_rd_en) begin
            failures++; $display("FAIL rd_excl: vid_rd_en=%b aux_rd_en=%b, want not both", vid_rd_en, aux_rd_en);
         end
         if (!sched_en) begin
            checks++;
            if (vid_rd_en || aux_rd_en) begin
               failures++; $display("FAIL pop_disabled: vid_rd_en=%b aux_rd_en=%b, want 0", vid_rd_en, aux_rd_en);
            end
         end
         if (prev_en_low) begin
            checks++;
            if (grant !== 2'b00) begin failures++; $display("FAIL grant_after_disable: got %b want 00", grant); end
         end
         if (pend) begin
            checks++;
            if ({out_valid, out_sel, out_data} !== {1'b1, pend_word}) begin
               failures++;
               $display("FAIL pop_latency: got v=%b sel=%b data=%h want v=1 sel=%b data=%h",
                        out_valid, out_sel, out_data, pend_word[29], pend_word[28:0]);
            end
         end
         if (prev_stall) begin
            checks++;
            if ({out_valid, out_sel, out_data} !== {1'b1, held} || pend) begin
               failures++;
               $display("FAIL stall_hold: got v=%b sel=%b data=%h popped=%b want v=1 sel=%b data=%h popped=0",
                        out_valid, out_sel, out_data, pend, held[29], held[28:0]);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++; $display("FAIL xfer_order: got sel=%b data=%h want no transfer", out_sel, out_data);
            end else begin
               if ({out_sel, out_data} !== exp_q[0]) begin
                  failures++;
                  $display("FAIL xfer_order: got sel=%b data=%h want sel=%b data=%h",
                           out_sel, out_data, exp_q[0][29], exp_q[0][28:0]);
               end
               exp_q.delete(0);
            end
         end
         if (vid_rd_en) c = "V"; else if (aux_rd_en) c = "A";
         else if (grant == 2'b01) c = "v"; else if (grant == 2'b10) c = "a"; else c = "-";
         trace.push_back(c);
         if (fair_on) begin
            if (aux_rd_en && vid_q.size() > 0) begin
               aux_run++; checks++;
               if (aux_run > AUX_B) begin failures++; $display("FAIL vid_fairness: aux pops %0d want <= %0d", aux_run, AUX_B); end
            end
            if (vid_rd_en || vid_q.size() == 0) aux_run = 0;
            if (vid_rd_en && aux_q.size() > 0) begin
               vid_run++; checks++;
               if (vid_run > VID_B) begin failures++; $display("FAIL aux_fairness: vid pops %0d want <= %0d", vid_run, VID_B); end
            end
            if (aux_rd_en || aux_q.size() == 0) vid_run = 0;
         end
         pend = 0;
         if (vid_rd_en && vid_q.size() > 0) begin
            pend = 1; pend_word = {1'b0, vid_q[0]}; pop_v = 1; vid_pops++; exp_q.push_back(pend_word);
         end else if (aux_rd_en && aux_q.size() > 0) begin
            pend = 1; pend_word = {1'b1, 5'b0, aux_q[0]}; pop_a = 1; aux_pops++; exp_q.push_back(pend_word);
         end
         prev_stall  = out_valid && !out_ready;
         held        = {out_sel, out_data};
         prev_en_low = !sched_en;
      end
   end

   always @(posedge clk125) begin
      #1;
      if (pop_v && vid_q.size() > 0) vid_q.delete(0);
      if (pop_a && aux_q.size() > 0) aux_q.delete(0);
      pop_v = 0; pop_a = 0;
      refresh();
   end

   task automatic do_reset();
      sys_rst_n = 1'b0; sched_en = 1'b0; out_ready = 1'b1; fair_on = 0;
      vid_q.delete(); aux_q.delete(); exp_q.delete();
      pop_v = 0; pop_a = 0; vid_pops = 0; aux_pops = 0;
      refresh();
      repeat (2) @(posedge clk125);
      #1 sys_rst_n = 1'b1;
      @(posedge clk125); #1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (out_valid !== 1'b0)  begin failures++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      checks++; if (out_sel !== 1'b0)    begin failures++; $display("FAIL reset_sel: got %b want 0", out_sel); end
      checks++; if (out_data !== 29'd0)  begin failures++; $display("FAIL reset_data: got %h want 0", out_data); end
      checks++; if (vid_rd_en !== 1'b0)  begin failures++; $display("FAIL reset_vid_rd: got %b want 0", vid_rd_en); end
      checks++; if (aux_rd_en !== 1'b0)  begin failures++; $display("FAIL reset_aux_rd: got %b want 0", aux_rd_en); end
      checks++; if (grant !== 2'b00)     begin failures++; $display("FAIL reset_grant: got %b want 00", grant); end
`ifdef SCHED_STAT_EN
      checks++;
      if ({stat_vid_words, stat_aux_words, stat_stall} !== 48'd0) begin
         failures++; $display("FAIL reset_stats: got %h %h %h want 0", stat_vid_words, stat_aux_words, stat_stall);
      end
`endif
   endtask

   task automatic run_trace(input string name, input int nv, input int na, input int len);
      do_reset();
      load(nv, na);
      trace.delete();
      sched_en = 1'b1;
      build_model(nv, na, 1'b0, len);
      for (int i = 0; i < len + 10 && trace.size() < len; i++) begin @(posedge clk125); #1; end
      compare_trace(name, len);
   endtask

   task automatic test_video_only();
      run_trace("video_only", 40, 0, 50);
   endtask

   task automatic test_both_loaded();
      run_trace("both_loaded", 64, 64, 140);
   endtask

   task automatic test_stall();
      do_reset();
      load(0, 32);
      sched_en = 1'b1;
      for (int i = 0; i < 50 && aux_pops < 3; i++) begin @(posedge clk125); #1; end
      out_ready = 1'b0;
      repeat (5) begin @(posedge clk125); #1; end
      checks++; if (aux_pops !== 3) begin failures++; $display("FAIL stall_no_pop: aux pops %0d want 3", aux_pops); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid: got %b want 1", out_valid); end
      out_ready = 1'b1;
      for (int i = 0; i < 100 && (aux_q.size() > 0 || exp_q.size() > 0); i++) begin @(posedge clk125); #1; end
      checks++; if (aux_pops !== 32) begin failures++; $display("FAIL stall_total: aux pops %0d want 32", aux_pops); end
   endtask

   task automatic test_aux_empty_mid();
      run_trace("aux_empty_mid", 5, 10, 25);
      load(0, 22);
      for (int i = 0; i < 200 && (aux_q.size() > 0 || exp_q.size() > 0); i++) begin @(posedge clk125); #1; end
      checks++; if (aux_pops !== 32) begin failures++; $display("FAIL aux_refill: aux pops %0d want 32", aux_pops); end
      checks++; if (vid_pops !== 5)  begin failures++; $display("FAIL aux_refill_vid: vid pops %0d want 5", vid_pops); end
   endtask

   task automatic test_sched_en_drop();
      int a0, v0;
      do_reset();
      load(20, 0);
      sched_en = 1'b1;
      for (int i = 0; i < 50 && vid_pops < 5; i++) begin @(posedge clk125); #1; end
      sched_en = 1'b0; out_ready = 1'b0;
      load(0, 4);
      repeat (3) begin @(posedge clk125); #1; end
      checks++; if (vid_pops !== 5) begin failures++; $display("FAIL en_drop_pops: vid pops %0d want 5", vid_pops); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL en_drop_held: out_valid %b want 1", out_valid); end
      checks++; if (grant !== 2'b00) begin failures++; $display("FAIL en_drop_idle: grant %b want 00", grant); end
      out_ready = 1'b1;
      @(posedge clk125); #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL en_drop_deliver: out_valid %b want 0", out_valid); end
      a0 = aux_pops; v0 = vid_pops;
      sched_en = 1'b1;
      for (int i = 0; i < 20 && aux_pops == a0 && vid_pops == v0; i++) begin @(posedge clk125); #1; end
      checks++;
      if (!(aux_pops > a0 && vid_pops == v0)) begin
         failures++; $display("FAIL en_drop_regrant: aux pops +%0d vid pops +%0d want aux first", aux_pops - a0, vid_pops - v0);
      end
      for (int i = 0; i < 200 && (vid_q.size() > 0 || aux_q.size() > 0 || exp_q.size() > 0); i++) begin @(posedge clk125); #1; end
      checks++; if (vid_pops !== 20 || aux_pops !== 4) begin
         failures++; $display("FAIL en_drop_drain: vid %0d aux %0d want 20 4", vid_pops, aux_pops);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      load(30, 0);
      sched_en = 1'b1;
      for (int i = 0; i < 50 && vid_pops < 3; i++) begin @(posedge clk125); #1; end
      #1 sys_rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, vid_rd_en, aux_rd_en, grant, out_data} !== 34'd0) begin
         failures++; $display("FAIL async_reset: v=%b vrd=%b ard=%b grant=%b data=%h want all 0",
                              out_valid, vid_rd_en, aux_rd_en, grant, out_data);
      end
`ifdef SCHED_STAT_EN
      checks++;
      if ({stat_vid_words, stat_aux_words, stat_stall} !== 48'd0) begin
         failures++; $display("FAIL async_reset_stats: got %h %h %h want 0", stat_vid_words, stat_aux_words, stat_stall);
      end
`endif
      do_reset();
   endtask

   task automatic test_random();
      int n;
      do_reset();
      for (int it = 0; it < 6; it++) begin
         fair_on = (it < 3);
         load($urandom_range(0, 60), $urandom_range(0, 80));
         sched_en = 1'b1;
         n = 0;
         while (n < 3000 && (vid_q.size() > 0 || aux_q.size() > 0 || exp_q.size() > 0)) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!fair_on) sched_en = ($urandom_range(0, 4) != 0);
            @(posedge clk125); #1;
            n++;
         end
         sched_en = 1'b1; out_ready = 1'b1;
         checks++;
         if (vid_q.size() != 0 || aux_q.size() != 0 || exp_q.size() != 0) begin
            failures++; $display("FAIL random_drain: left vid=%0d aux=%0d out=%0d want 0 0 0",
                                 vid_q.size(), aux_q.size(), exp_q.size());
         end
      end
      fair_on = 0;
   endtask

   initial begin
      sys_rst_n = 1'b0; sched_en = 1'b0; out_ready = 1'b1;
      refresh();
      test_reset();
      test_video_only();
      test_both_loaded();
      test_stall();
      test_aux_empty_mid();
      test_sched_en_drop();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1);
   end

endmodule
